// File: rtl/div_frec_pkg.sv
// Shared definitions for the programmable frequency divider: state encoding,
// default widths/prescale and a counter-width helper.
package div_frec_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int DIV_WIDTH = 8;
    localparam int PRESC_DEF = 100000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/div_frec_prog_tick_presc.sv
// Base-tick prescaler: free-running 0..PRESC-1 counter, held at zero by clr_i.
module tick_presc
    import div_frec_pkg::*;
#(
    parameter int PRESC = PRESC_DEF
) (
    input  logic clk_i,
    input  logic reset,
    input  logic clr_i,
    output logic bt_o
);
    localparam int            PW   = cnt_w(PRESC);
    localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

    logic [PW-1:0] r_pre_cnt;

    always_ff @(posedge clk_i) begin
        if (reset || clr_i)
            r_pre_cnt <= '0;
        else if (r_pre_cnt == LAST)
            r_pre_cnt <= '0;
        else
            r_pre_cnt <= r_pre_cnt + PW'(1);
    end

    // With PRESC=1 the counter sits at LAST, so every enabled cycle is a tick.
    assign bt_o = (r_pre_cnt == LAST) && !clr_i;
endmodule

// File: rtl/div_frec_prog.sv
// Programmable 50%-duty divider: half-period = div word * PRESC cycles; the
// divide word is reloaded only at half-period boundaries so no runt pulses occur.
module div_frec_prog
    import div_frec_pkg::*;
#(
    parameter int PRESC = PRESC_DEF,
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    output logic             sq_o,
    output logic             edge_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] div_o
);
    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_hp_cnt, w_hp_nx;
    logic [WIDTH-1:0] r_div_q, w_div_nx;
    logic             r_sq, w_sq_nx;
    logic             r_edge, w_edge_nx;
    logic             w_bt;
    logic             w_clr;

    // Prescaler is held clear whenever we are idle or about to drop to idle.
    assign w_clr = (r_state == IDLE) || !en_i;

    tick_presc #(.PRESC(PRESC)) u_tick (
        .clk_i (clk_i),
        .reset (reset),
        .clr_i (w_clr),
        .bt_o  (w_bt)
    );

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hp_cnt <= '0;
            r_div_q  <= '0;
            r_sq     <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_hp_cnt <= w_hp_nx;
            r_div_q  <= w_div_nx;
            r_sq     <= w_sq_nx;
            r_edge   <= w_edge_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_hp_nx    = r_hp_cnt;
        w_div_nx   = r_div_q;
        w_sq_nx    = r_sq;
        w_edge_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                w_sq_nx = 1'b0;
                w_hp_nx = '0;
                if (en_i && (div_i != '0)) begin
                    w_div_nx   = div_i;
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (!en_i) begin
                    w_state_nx = IDLE;
                    w_sq_nx    = 1'b0;
                    w_hp_nx    = '0;
                    w_div_nx   = '0;
                end else if (w_bt) begin
                    if (r_hp_cnt == r_div_q - WIDTH'(1)) begin
                        // Half-period boundary: the only place div_i is sampled.
                        w_hp_nx  = '0;
                        w_div_nx = div_i;
                        if (div_i != '0) begin
                            w_sq_nx   = ~r_sq;
                            w_edge_nx = 1'b1;
                        end else begin
                            w_sq_nx    = 1'b0;
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_hp_nx = r_hp_cnt + WIDTH'(1);
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign sq_o   = r_sq;
    assign edge_o = r_edge;
    assign busy_o = (r_state == RUN);
    assign div_o  = r_div_q;
endmodule

// File: tb/tb_div_frec_prog.sv
// Directed bench for div_frec_prog: PRESC=4 instance for the main scenarios,
// PRESC=1 instance for the minimum-setting case.
module tb_div_frec_prog;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] div = 8'd0;
    logic       sq, edge_p, busy;
    logic [7:0] div_o;

    logic       en_m = 1'b0;
    logic [7:0] div_m = 8'd0;
    logic       sq_m, edge_m, busy_m;
    logic [7:0] div_o_m;

    int         n_run = 0;
    int         n_fail = 0;
    int         t = 0;
    int         nb = 0;
    logic       running = 1'b0;
    logic       e_sq = 1'b0;
    logic       e_edge = 1'b0;
    logic [7:0] e_div = 8'd0;

    always #5 clk = ~clk;

    div_frec_prog #(.PRESC(P), .WIDTH(8)) u_dut (
        .clk_i  (clk),
        .reset  (reset),
        .en_i   (en),
        .div_i  (div),
        .sq_o   (sq),
        .edge_o (edge_p),
        .busy_o (busy),
        .div_o  (div_o)
    );

    div_frec_prog #(.PRESC(1), .WIDTH(8)) u_min (
        .clk_i  (clk),
        .reset  (reset),
        .en_i   (en_m),
        .div_i  (div_m),
        .sq_o   (sq_m),
        .edge_o (edge_m),
        .busy_o (busy_m),
        .div_o  (div_o_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h (busy,sq,edge,div)", tag, t, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Enter RUN from IDLE with divide word d and restart the reference timeline.
    task automatic start(input logic [7:0] d);
        en = 1'b1;
        div = d;
        tick();
        t = 0;
        running = 1'b1;
        e_sq = 1'b0;
        e_edge = 1'b0;
        e_div = d;
        nb = d * P;
        chk("start", {busy, sq, edge_p, div_o}, {1'b1, 1'b0, 1'b0, d});
    endtask

    // One clock with the expected outputs derived from the boundary schedule.
    task automatic step_chk(input string tag);
        tick();
        t++;
        e_edge = 1'b0;
        if (running) begin
            if (!en) begin
                running = 1'b0;
                e_sq = 1'b0;
                e_div = 8'd0;
            end else if (t == nb) begin
                e_div = div;
                if (div != 8'd0) begin
                    e_sq = ~e_sq;
                    e_edge = 1'b1;
                    nb = nb + div * P;
                end else begin
                    running = 1'b0;
                    e_sq = 1'b0;
                end
            end
        end
        chk(tag, {busy, sq, edge_p, div_o}, {running, e_sq, e_edge, e_div});
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b1;
        div = 8'd3;
        repeat (3) begin
            tick();
            chk("reset", {busy, sq, edge_p, div_o}, 32'd0);
            chk("reset_min", {busy_m, sq_m, edge_m, div_o_m}, 32'd0);
        end
        reset = 1'b0;
        start(8'd3);

        repeat (53) step_chk("run3");
        div = 8'd5;
        repeat (57) step_chk("chg5");
        div = 8'd0;
        repeat (15) step_chk("stop0");

        start(8'd2);
        repeat (13) step_chk("run2");
        en = 1'b0;
        repeat (6) step_chk("en_drop");

        start(8'd3);
        repeat (7) step_chk("run3b");
        reset = 1'b1;
        tick();
        chk("reset_mid", {busy, sq, edge_p, div_o}, 32'd0);
        reset = 1'b0;
        start(8'd3);
        repeat (14) step_chk("rerun");
        en = 1'b0;
        tick();

        en_m = 1'b1;
        div_m = 8'd1;
        tick();
        chk("min_start", {busy_m, sq_m, edge_m, div_o_m}, {1'b1, 1'b0, 1'b0, 8'd1});
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("min_run", {busy_m, sq_m, edge_m, div_o_m}, {1'b1, (i % 2 == 1), 1'b1, 8'd1});
        end
        en_m = 1'b0;
        tick();
        chk("min_stop", {busy_m, sq_m, edge_m, div_o_m}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
